// File: rtl/bit_slicer_pkg.sv
// Shared types and constants for the 32-to-16 bit slicing path.
// Holds the sequencer state encoding, the half width and the per-word mask codes.
package bit_slicer_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_FIRST  = 2'd1,
    SEQ_SECOND = 2'd2
  } seq_state_e;

  localparam int HALF_W = 16;

  localparam logic [1:0] MASK_NONE = 2'b00;
  localparam logic [1:0] MASK_LO   = 2'b01;
  localparam logic [1:0] MASK_HI   = 2'b10;
  localparam logic [1:0] MASK_BOTH = 2'b11;

  // True when the first half presented for a word is the high half.
  function automatic logic first_is_hi(input logic [1:0] mask, input logic hi_first);
    logic r;
    r = 1'b0;
    case (mask)
      MASK_LO:   r = 1'b0;
      MASK_HI:   r = 1'b1;
      MASK_BOTH: r = hi_first;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/halfword_sequencer_if.sv
// Word-in / half-out handshake bundle of the halfword sequencer.
// The slave view belongs to the sequencer, the master view to whoever drives it.
interface halfword_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DATA_W-1:0]     in_data_i;
  logic [1:0]            in_mask_i;
  logic                  hi_first_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_W/2-1:0]   out_data_o;
  logic                  out_last_o;
  logic                  sel_o;
  logic [CNT_W-1:0]      half_cnt_o;

  modport slave (
    input  in_valid_i, in_data_i, in_mask_i, hi_first_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_last_o, sel_o, half_cnt_o
  );

  modport master (
    output in_valid_i, in_data_i, in_mask_i, hi_first_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_last_o, sel_o, half_cnt_o
  );
endinterface

// File: rtl/halfword_sequencer.sv
// Accepts words and emits their masked 16-bit halves one per cycle, in a
// selectable order, while steering the slicer half-select and counting halves.
module halfword_sequencer
  import bit_slicer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input logic                clk_i,
  input logic                rst_ni,
  halfword_sequencer_if.slave bus
);

  localparam int HW = DATA_W / 2;

  seq_state_e        r_state;
  seq_state_e        w_state_nxt;
  logic [DATA_W-1:0] r_word;
  logic [1:0]        r_mask;
  logic              r_hi_first;
  logic [CNT_W-1:0]  r_cnt;

  logic w_valid;
  logic w_hi_sel;
  logic w_last;
  logic w_out_fire;
  logic w_done;
  logic w_in_ready;
  logic w_in_fire;

  // Which half is on the bus is derived purely from held state, so it stays
  // frozen for as long as the downstream stalls.
  always_comb begin
    w_valid  = (r_state != SEQ_IDLE);
    w_hi_sel = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      SEQ_FIRST: begin
        w_hi_sel = first_is_hi(r_mask, r_hi_first);
        w_last   = (r_mask != MASK_BOTH);
      end
      SEQ_SECOND: begin
        w_hi_sel = ~r_hi_first;
        w_last   = 1'b1;
      end
      default: begin
        w_hi_sel = 1'b0;
        w_last   = 1'b0;
      end
    endcase
  end

  assign w_out_fire = w_valid & bus.out_ready_i;
  assign w_done     = w_out_fire & w_last;
  // Combinational from out_ready_i: a finishing word frees the register this cycle.
  assign w_in_ready = (r_state == SEQ_IDLE) | w_done;
  assign w_in_fire  = bus.in_valid_i & w_in_ready;

  always_comb begin
    w_state_nxt = r_state;
    if (w_in_fire) begin
      w_state_nxt = (bus.in_mask_i == MASK_NONE) ? SEQ_IDLE : SEQ_FIRST;
    end else if (w_out_fire) begin
      w_state_nxt = (r_state == SEQ_FIRST && !w_last) ? SEQ_SECOND : SEQ_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= SEQ_IDLE;
      r_word     <= '0;
      r_mask     <= MASK_NONE;
      r_hi_first <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_in_fire) begin
        r_word     <= bus.in_data_i;
        r_mask     <= bus.in_mask_i;
        r_hi_first <= bus.hi_first_i;
      end
      if (w_out_fire) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = w_valid;
  assign bus.out_last_o  = w_last;
  assign bus.sel_o       = ~w_hi_sel;
  assign bus.out_data_o  = !w_valid ? '0 :
                           (w_hi_sel ? r_word[DATA_W-1:HW] : r_word[HW-1:0]);
  assign bus.half_cnt_o  = r_cnt;

endmodule

// File: tb/tb_halfword_sequencer.sv
// Bench for halfword_sequencer: directed scenarios plus random traffic, checked
// every cycle against a queue of pending halves built from the word rules.
module tb_halfword_sequencer;
  import bit_slicer_pkg::HALF_W;

  localparam int DW = 32;
  localparam int CW = 4;

  logic clk;
  logic rst_n;

  halfword_sequencer_if #(.DATA_W(DW), .CNT_W(CW)) ifc();

  halfword_sequencer #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [HALF_W-1:0] d;
    logic              sel;
  } half_t;

  half_t       q[$];
  int unsigned mcnt;
  int          total;
  int          bad;
  logic        pushed;
  logic        rnd_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_in_ready();
    return (q.size() == 0) || (q.size() == 1 && ifc.out_ready_i);
  endfunction

  task automatic push_word(input logic [31:0] w, input logic [1:0] m, input logic hf);
    half_t lo, hi;
    lo.d = w[15:0];  lo.sel = 1'b1;
    hi.d = w[31:16]; hi.sel = 1'b0;
    case (m)
      2'b01: q.push_back(lo);
      2'b10: q.push_back(hi);
      2'b11: begin
        if (hf) begin q.push_back(hi); q.push_back(lo); end
        else    begin q.push_back(lo); q.push_back(hi); end
      end
      default: ;
    endcase
  endtask

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    logic do_pop, do_push;
    logic [31:0] w;
    logic [1:0]  m;
    logic        hf;
    @(negedge clk);
    chk("in_ready", 32'(ifc.in_ready_o), 32'(exp_in_ready()));
    chk("out_valid", 32'(ifc.out_valid_o), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_data", 32'(ifc.out_data_o), 32'(q[0].d));
      chk("sel", 32'(ifc.sel_o), 32'(q[0].sel));
      chk("out_last", 32'(ifc.out_last_o), 32'(q.size() == 1));
    end
    chk("half_cnt", 32'(ifc.half_cnt_o), mcnt % 16);
    do_pop  = (q.size() != 0) && ifc.out_ready_i;
    do_push = ifc.in_valid_i && exp_in_ready();
    w  = ifc.in_data_i;
    m  = ifc.in_mask_i;
    hf = ifc.hi_first_i;
    @(posedge clk);
    if (do_pop) begin
      void'(q.pop_front());
      mcnt++;
    end
    if (do_push) push_word(w, m, hf);
    pushed = do_push;
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic [1:0] m, input logic hf);
    int n;
    ifc.in_valid_i = 1'b1;
    ifc.in_data_i  = w;
    ifc.in_mask_i  = m;
    ifc.hi_first_i = hf;
    n = 0;
    pushed = 1'b0;
    while (!pushed && n < 60) begin
      if (rnd_ready) ifc.out_ready_i = ($urandom_range(0, 9) < 7);
      cycle();
      n++;
    end
    if (!pushed) chk("send_timeout", 32'(pushed), 32'd1);
    ifc.in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    ifc.in_valid_i  = 1'b0;
    ifc.out_ready_i = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      cycle();
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    total = 0; bad = 0; mcnt = 0; pushed = 1'b0; rnd_ready = 1'b0;
    rst_n = 1'b0;
    ifc.in_valid_i  = 1'b0;
    ifc.in_data_i   = '0;
    ifc.in_mask_i   = 2'b00;
    ifc.hi_first_i  = 1'b0;
    ifc.out_ready_i = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(ifc.out_valid_o), 32'd0);
    chk("rst_cnt", 32'(ifc.half_cnt_o), 32'd0);
    chk("rst_sel", 32'(ifc.sel_o), 32'd1);
    chk("rst_data", 32'(ifc.out_data_o), 32'd0);
    chk("rst_last", 32'(ifc.out_last_o), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(ifc.in_ready_o), 32'd1);
    cycle();

    // Both halves, low first, no stall
    ifc.out_ready_i = 1'b1;
    send(32'hAAAA5555, 2'b11, 1'b0);
    chk("first_half", 32'(ifc.out_data_o), 32'h5555);
    cycle();
    chk("second_half", 32'(ifc.out_data_o), 32'hAAAA);
    cycle();
    chk("cnt_two", 32'(ifc.half_cnt_o), 32'd2);

    // High first with a 3-cycle stall; later hi_first changes and a waiting word
    send(32'hAAAA5555, 2'b11, 1'b1);
    ifc.out_ready_i = 1'b0;
    ifc.in_valid_i  = 1'b1;
    ifc.in_data_i   = 32'h12345678;
    ifc.in_mask_i   = 2'b01;
    ifc.hi_first_i  = 1'b0;
    repeat (3) cycle();
    chk("stall_data", 32'(ifc.out_data_o), 32'hAAAA);
    chk("stall_cnt", 32'(ifc.half_cnt_o), 32'd2);
    ifc.out_ready_i = 1'b1;
    cycle();
    chk("after_stall", 32'(ifc.out_data_o), 32'h5555);
    cycle();
    chk("queued_word", 32'(ifc.out_data_o), 32'h5678);
    drain();

    // Back-to-back stream with a dropped middle word
    send(32'h11112222, 2'b01, 1'b1);
    send(32'h33334444, 2'b00, 1'b0);
    send(32'h55556666, 2'b10, 1'b0);
    drain();

    // Random traffic long enough to wrap the 4-bit counter several times
    rnd_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) begin
        ifc.out_ready_i = 1'($urandom_range(0, 1));
        cycle();
      end
    end
    rnd_ready = 1'b0;
    drain();

    // Reset during the second half of a word
    send(32'hDEADBEEF, 2'b11, 1'b0);
    cycle();
    chk("pre_rst_second", 32'(ifc.out_data_o), 32'hDEAD);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ifc.out_valid_o), 32'd0);
    chk("mid_rst_cnt", 32'(ifc.half_cnt_o), 32'd0);
    chk("mid_rst_data", 32'(ifc.out_data_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    mcnt = 0;
    repeat (3) cycle();
    send(32'hCAFEF00D, 2'b11, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
